des_round_sequencer: RTL and testbench

Iterative DES engine controller. It accepts one 64-bit block and 64-bit key per transaction and applies IP and PC-1. It then runs 16 Feistel rounds over 16 consecutive cycles through a single shared, external f-function (E_box → key XOR → S-boxes → P). It generates each round's subkey on the fly (rotations + PC-2), and finally applies FP and presents the result with a valid/ready handshake. It sits between the block-level host interface and the existing combinational f-function datapath, and owns all round sequencing and key scheduling.

---
 rtl/des_round_sequencer.sv | 174 +++++++++++++++++
 tb/tb_des_round_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP/PC-1 on accept, 16 Feistel rounds through an external
// f-function with on-the-fly subkey generation, then FP and a valid/ready result port.
module des_round_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [0:63] block_in,
  input  logic [0:63] key_in,
  output logic [0:31] f_r,
  output logic [0:47] f_k,
  input  logic [0:31] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] block_out,
  output logic [3:0]  round_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  // Permutation tables use DES 1-based bit numbers; bit 0 of a vector is DES bit 1.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  state_t      state_q, state_d;
  logic [0:31] l_q, l_d, r_q, r_d;
  logic [0:27] c_q, c_d, d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        mode_q, mode_d;
  logic [0:63] block_out_q, block_out_d;

  logic [0:63] ip_w, fp_in_w, fp_w;
  logic [0:55] pc1_w, cd_rot_w;
  logic [0:47] pc2_w;
  logic [0:27] c_rot, d_rot;
  logic        shift_one;
  logic        unused_parity;

  assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                           key_in[39], key_in[47], key_in[55], key_in[63]};

  // Final round writes {R16, L16} = {L15 ^ f, R15}; FP sees the un-swapped halves.
  assign fp_in_w  = {l_q ^ f_out, r_q};
  assign cd_rot_w = {c_rot, d_rot};

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_ip_fp
      assign ip_w[gi] = block_in[IP_T[gi] - 1];
      assign fp_w[gi] = fp_in_w[FP_T[gi] - 1];
    end
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_w[gi] = key_in[PC1_T[gi] - 1];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_w[gi] = cd_rot_w[PC2_T[gi] - 1];
    end
  endgenerate

  // Rounds 1,2,9,16 shift by one; decrypt mirrors the schedule right-wards and skips round 1.
  always_comb begin
    shift_one = (rnd_q == 4'd0) || (rnd_q == 4'd1) || (rnd_q == 4'd8) || (rnd_q == 4'd15);
    c_rot = c_q;
    d_rot = d_q;
    if (!mode_q) begin
      if (shift_one) begin
        c_rot = {c_q[1:27], c_q[0]};
        d_rot = {d_q[1:27], d_q[0]};
      end else begin
        c_rot = {c_q[2:27], c_q[0:1]};
        d_rot = {d_q[2:27], d_q[0:1]};
      end
    end else if (rnd_q != 4'd0) begin
      if (shift_one) begin
        c_rot = {c_q[27], c_q[0:26]};
        d_rot = {d_q[27], d_q[0:26]};
      end else begin
        c_rot = {c_q[26:27], c_q[0:25]};
        d_rot = {d_q[26:27], d_q[0:25]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      block_out_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      rnd_q       <= rnd_d;
      mode_q      <= mode_d;
      block_out_q <= block_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ROUND;
      S_ROUND: if (rnd_q == 4'd15) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    rnd_d       = rnd_q;
    mode_d      = mode_q;
    block_out_d = block_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip_w;
          {c_d, d_d} = pc1_w;
          rnd_d      = 4'd0;
          mode_d     = decrypt;
        end
      end
      S_ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        c_d   = c_rot;
        d_d   = d_rot;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd15) block_out_d = fp_w;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    round_idx = (state_q == S_ROUND) ? rnd_q : 4'd0;
  end

  assign f_r       = r_q;
  assign f_k       = pc2_w;
  assign block_out = block_out_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a behavioural DES f-function and a
// scoreboard of known-answer results.
module tb_des_round_sequencer;

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,  24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT3  = 64'h8787878787878787;
  localparam logic [63:0] KEY3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT3  = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, decrypt, out_valid, out_ready;
  logic [0:63] block_in, key_in, block_out;
  logic [0:31] f_r, f_out;
  logic [0:47] f_k;
  logic [3:0]  round_idx;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
    .block_in(block_in), .key_in(key_in), .f_r(f_r), .f_k(f_k), .f_out(f_out),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out), .round_idx(round_idx)
  );

  function automatic logic [0:31] des_f(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s_o, res;
    logic [5:0]  six;
    int          v;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1] ^ k[i];
    for (int s = 0; s < 8; s++) begin
      six = x[6*s +: 6];
      v = SB[s*64 + int'({six[5], six[0]})*16 + int'(six[4:1])];
      s_o[4*s +: 4] = 4'(v);
    end
    for (int i = 0; i < 32; i++) res[i] = s_o[P_T[i] - 1];
    return res;
  endfunction

  always_comb f_out = des_f(f_r, f_k);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge inside round 1, with acc_cyc marking that cycle.
  task automatic send(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                      input logic [63:0] exp, input bit push, output int acc_cyc);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    block_in = blk;
    key_in   = key;
    decrypt  = dec;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (push) exp_q.push_back(exp);
    $display("accept: block=%h key=%h decrypt=%0d expect=%h", blk, key, dec, exp);
  endtask

  task automatic collect(input string tag, input int acc_cyc, input int hold, input int pulse_at);
    logic [63:0] exp;
    int bad;
    bit seen;
    bad  = 0;
    seen = 1'b0;
    exp  = '0;
    out_ready = (hold == 0);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (round_idx != 4'(cyc - acc_cyc)) bad++;
      if (in_ready) bad++;
      if (pulse_at >= 0 && int'(round_idx) == pulse_at) begin
        in_valid = 1'b1;
        block_in = CT1;
        key_in   = KEY1;
        decrypt  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_round_seq"}, 64'(bad), 64'd0);
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd16);
    chk({tag, "_sb_nonempty"}, {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    chk({tag, "_block_out"}, block_out, exp);
    $display("result %s: block_out=%h expected=%h latency=%0d", tag, block_out, exp, cyc - acc_cyc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_data"}, block_out, exp);
      chk({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_after_hs_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_after_hs_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int acc, quiet, n_acc, n_res;
    int acc_at [2];
    bit found, pend;
    logic [63:0] exp;

    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
    block_in = '0; key_in = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_block_out", block_out, 64'd0);
    chk("rst_round_idx", 64'(round_idx), 64'd0);
    chk("rst_f_r", 64'(f_r), 64'd0);
    chk("rst_f_k", 64'(f_k), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Known-answer encrypt; round-1 subkey K1 is a published value.
    send(PT1, KEY1, 1'b0, CT1, 1'b1, acc);
    chk("enc_round1_fk", 64'(f_k), 64'h1B02EFFC7072);
    collect("enc1", acc, 0, -1);

    // Decrypt starts from K16.
    send(CT1, KEY1, 1'b1, PT1, 1'b1, acc);
    chk("dec_round1_fk", 64'(f_k), 64'hCB3D8B0E17F5);
    collect("dec1", acc, 0, -1);

    send(PT3, KEY3, 1'b0, CT3, 1'b1, acc);
    collect("enc3_hold", acc, 5, -1);

    // A block offered mid-flight must be dropped; it is taken only after the handshake.
    send(PT3, KEY3, 1'b0, CT3, 1'b1, acc);
    collect("enc3_pulse", acc, 0, 7);
    send(CT1, KEY1, 1'b1, PT1, 1'b1, acc);
    collect("dec_after_pulse", acc, 0, -1);

    // Reset in flight: the aborted block is never pushed and must never appear.
    send(PT1, KEY1, 1'b0, CT1, 1'b0, acc);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (round_idx == 4'd9) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_round9", {63'd0, found}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_block_out", block_out, 64'd0);
    chk("midrst_round_idx", 64'(round_idx), 64'd0);
    $display("reset at round_idx=9: in_ready=%0d out_valid=%0d block_out=%h", in_ready, out_valid, block_out);
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) quiet++;
      @(negedge clk);
    end
    chk("no_output_after_rst", 64'(quiet), 64'd0);
    send(PT1, KEY1, 1'b0, CT1, 1'b1, acc);
    collect("enc1_after_rst", acc, 0, -1);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    @(negedge clk);
    block_in = PT1; key_in = KEY1; decrypt = 1'b0; in_valid = 1'b1;
    n_acc = 0; n_res = 0; pend = 1'b0;
    acc_at[0] = 0; acc_at[1] = 0;
    for (int k = 0; k < 60 && n_res < 2; k++) begin
      if (pend) begin
        pend = 1'b0;
        n_acc++;
        if (n_acc == 1) begin
          block_in = PT3;
          key_in   = KEY3;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        exp = '0;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        chk("b2b_block_out", block_out, exp);
        $display("result b2b%0d: block_out=%h expected=%h", n_res, block_out, exp);
        n_res++;
      end
      if (in_valid && in_ready && n_acc < 2) begin
        pend = 1'b1;
        acc_at[n_acc] = cyc;
        exp_q.push_back(n_acc == 0 ? CT1 : CT3);
        $display("accept b2b%0d at cycle %0d", n_acc, cyc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_results", 64'(n_res), 64'd2);
    chk("b2b_period", 64'(acc_at[1] - acc_at[0]), 64'd18);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
